// File: rtl/mac_fifo_writer.sv
// mac_fifo_writer
//   Pipelined multiply / multiply-accumulate producer feeding the write side of
//   the MAC datapath async FIFO. Operand pairs arrive over valid/ready; each
//   product either goes straight to the FIFO or is folded into a saturating sum
//   of ACC_LEN products. wFull stalls the whole pipeline without loss.
//
// Ports
//   clk       clock
//   reset     synchronous, active-high reset
//   acc_mode  0 = multiply mode, 1 = accumulate mode
//   in_valid  operand pair valid
//   in_ready  block can accept an operand pair this cycle
//   D1, D2    operands A and B (unsigned, WIDTH bits)
//   wFull     FIFO full (write domain)
//   wr_En     FIFO write strobe
//   wr_data   FIFO write data (ACC_WIDTH bits)
//   sat_flag  wr_data was saturated (qualified by wr_En)
//   busy      any pipeline stage, partial group or output register occupied

module mac_fifo_writer #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned STAGES    = 2,
    parameter int unsigned ACC_LEN   = 4,
    parameter int unsigned ACC_WIDTH = 2 * WIDTH + 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 acc_mode,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     D1,
    input  logic [WIDTH-1:0]     D2,
    input  logic                 wFull,
    output logic                 wr_En,
    output logic [ACC_WIDTH-1:0] wr_data,
    output logic                 sat_flag,
    output logic                 busy
);

    localparam int unsigned PW    = 2 * WIDTH;
    // Product register at accept plus STAGES multiplier stages: an accepted pair
    // reaches the output register STAGES+1 edges after the accept edge.
    localparam int unsigned PipeD = STAGES + 1;
    localparam int unsigned CntW  = $clog2(ACC_LEN);

    localparam logic [CntW-1:0] LastCnt = CntW'(ACC_LEN - 1);

    logic [PipeD-1:0]     vld_q, vld_d;
    logic [PW-1:0]        prod_q [PipeD];
    logic [PW-1:0]        prod_d [PipeD];
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 acc_sat_q, acc_sat_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
    logic                 out_sat_q, out_sat_d;
    logic                 mode_q, mode_d;

    logic                 adv;
    logic                 mode_block;
    logic                 accept;
    logic [PW-1:0]        mul;
    logic                 last_vld;
    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH-1:0] acc_base;
    logic [ACC_WIDTH:0]   sum_full;
    logic                 ovf;
    logic [ACC_WIDTH-1:0] sum_sat;
    logic                 grp_sat;
    logic                 grp_done;

    // Handshake, stall and status
    always_comb begin
        busy       = (|vld_q) | (cnt_q != '0) | out_valid_q;
        // Everything moves unless a result is waiting and the FIFO is full.
        adv        = ~out_valid_q | ~wFull;
        // A pending mode change waits for the pipe to drain so groups never mix.
        mode_block = busy & (acc_mode != mode_q);
        in_ready   = adv & ~mode_block;
        accept     = in_valid & in_ready;
        wr_En      = out_valid_q & ~wFull;
        wr_data    = out_data_q;
        sat_flag   = out_sat_q;
    end

    // Arithmetic on the last pipeline stage
    always_comb begin
        mul      = PW'(D1) * PW'(D2);
        last_vld = vld_q[PipeD-1];
        prod_ext = ACC_WIDTH'(prod_q[PipeD-1]);
        // count==0 marks the first product of a group; acc is ignored then.
        acc_base = (cnt_q == '0) ? '0 : acc_q;
        sum_full = {1'b0, acc_base} + {1'b0, prod_ext};
        ovf      = sum_full[ACC_WIDTH];
        sum_sat  = ovf ? '1 : sum_full[ACC_WIDTH-1:0];
        grp_sat  = ((cnt_q != '0) & acc_sat_q) | ovf;
        grp_done = (cnt_q == LastCnt);
    end

    // Next state
    always_comb begin
        vld_d       = vld_q;
        prod_d      = prod_q;
        acc_d       = acc_q;
        acc_sat_d   = acc_sat_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        mode_d      = busy ? mode_q : acc_mode;

        if (adv) begin
            vld_d[0]  = accept;
            prod_d[0] = mul;
            for (int i = 1; i < PipeD; i++) begin
                vld_d[i]  = vld_q[i-1];
                prod_d[i] = prod_q[i-1];
            end

            // adv with out_valid set implies the current result is being written,
            // so the register empties unless a new result lands this edge.
            out_valid_d = 1'b0;

            if (last_vld) begin
                if (!mode_q) begin
                    out_valid_d = 1'b1;
                    out_data_d  = prod_ext;
                    out_sat_d   = 1'b0;
                end else if (grp_done) begin
                    out_valid_d = 1'b1;
                    out_data_d  = sum_sat;
                    out_sat_d   = grp_sat;
                    cnt_d       = '0;
                    acc_d       = '0;
                    acc_sat_d   = 1'b0;
                end else begin
                    acc_d     = sum_sat;
                    acc_sat_d = grp_sat;
                    cnt_d     = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q       <= '0;
            for (int i = 0; i < PipeD; i++) begin
                prod_q[i] <= '0;
            end
            acc_q       <= '0;
            acc_sat_q   <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            mode_q      <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            prod_q      <= prod_d;
            acc_q       <= acc_d;
            acc_sat_q   <= acc_sat_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            mode_q      <= mode_d;
        end
    end

endmodule

// File: tb/tb_mac_fifo_writer.sv
// tb_mac_fifo_writer
//   Drives two instances from one stimulus stream: A with default parameters and
//   B with ACC_WIDTH=9 so saturation can be exercised. Expected results are
//   pushed to per-instance queues when a pair is accepted and popped whenever
//   the matching instance strobes wr_En.

module tb_mac_fifo_writer;

    logic       clk = 1'b0;
    logic       reset;
    logic       acc_mode;
    logic       in_valid;
    logic       wfull;
    logic [3:0] d1;
    logic [3:0] d2;

    logic        in_ready_a, wr_en_a, sat_a, busy_a;
    logic [11:0] wr_data_a;
    logic        in_ready_b, wr_en_b, sat_b, busy_b;
    logic [8:0]  wr_data_b;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;
    int pushes    = 0;
    int writes_a  = 0;
    int writes_b  = 0;

    logic [12:0] qa[$];
    logic [9:0]  qb[$];

    // Reference accumulator state per instance (index 0 = A, 1 = B)
    int m_acc [2];
    int m_sat [2];
    int m_max [2];
    int m_cnt = 0;

    always #5 clk = ~clk;

    mac_fifo_writer u_dut_a (
        .clk      (clk),
        .reset    (reset),
        .acc_mode (acc_mode),
        .in_valid (in_valid),
        .in_ready (in_ready_a),
        .D1       (d1),
        .D2       (d2),
        .wFull    (wfull),
        .wr_En    (wr_en_a),
        .wr_data  (wr_data_a),
        .sat_flag (sat_a),
        .busy     (busy_a)
    );

    mac_fifo_writer #(
        .ACC_WIDTH (9)
    ) u_dut_b (
        .clk      (clk),
        .reset    (reset),
        .acc_mode (acc_mode),
        .in_valid (in_valid),
        .in_ready (in_ready_b),
        .D1       (d1),
        .D2       (d2),
        .wFull    (wfull),
        .wr_En    (wr_en_b),
        .wr_data  (wr_data_b),
        .sat_flag (sat_b),
        .busy     (busy_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input int a, input int b, input logic mode);
        int p;
        int s;
        int st;
        p = a * b;
        if (!mode) begin
            qa.push_back({1'b0, 12'(p)});
            qb.push_back({1'b0, 9'(p)});
            pushes++;
        end else begin
            for (int k = 0; k < 2; k++) begin
                s  = ((m_cnt == 0) ? 0 : m_acc[k]) + p;
                st = (m_cnt == 0) ? 0 : m_sat[k];
                if (s > m_max[k]) begin
                    s  = m_max[k];
                    st = 1;
                end
                m_acc[k] = s;
                m_sat[k] = st;
            end
            if (m_cnt == 3) begin
                qa.push_back({1'(m_sat[0]), 12'(m_acc[0])});
                qb.push_back({1'(m_sat[1]), 9'(m_acc[1])});
                pushes++;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
    endtask

    // Present a pair until accepted; reports how many cycles it was refused.
    task automatic send(input int a, input int b, output int stalls);
        logic got;
        got      = 1'b0;
        stalls   = 0;
        in_valid = 1'b1;
        d1       = 4'(a);
        d2       = 4'(b);
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            if (in_ready_a) begin
                model_accept(a, b, acc_mode);
                got = 1'b1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        check("send accepted", {31'd0, got}, 32'd1);
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((qa.size() != 0 || qb.size() != 0 || busy_a || busy_b) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(tag, {31'd0, (n < 100)}, 32'd1);
    endtask

    // Scoreboard monitors
    always @(negedge clk) begin
        logic [31:0] exp;
        if (wr_en_a) begin
            writes_a++;
            exp = (qa.size() != 0) ? {19'd0, qa.pop_front()} : 32'hDEAD_BEEF;
            check("A write {sat,data}", {19'd0, sat_a, wr_data_a}, exp);
        end
        if (wr_en_b) begin
            writes_b++;
            exp = (qb.size() != 0) ? {22'd0, qb.pop_front()} : 32'hDEAD_BEEF;
            check("B write {sat,data}", {22'd0, sat_b, wr_data_b}, exp);
        end
    end

    initial begin
        int st;
        int w0;

        m_max[0] = 4095;
        m_max[1] = 511;
        m_acc[0] = 0;
        m_acc[1] = 0;
        m_sat[0] = 0;
        m_sat[1] = 0;

        reset    = 1'b1;
        acc_mode = 1'b0;
        in_valid = 1'b0;
        wfull    = 1'b0;
        d1       = '0;
        d2       = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("reset wr_En", {31'd0, wr_en_a}, 32'd0);
        check("reset wr_data", {20'd0, wr_data_a}, 32'd0);
        check("reset sat_flag", {31'd0, sat_a}, 32'd0);
        check("reset busy A", {31'd0, busy_a}, 32'd0);
        check("reset busy B", {31'd0, busy_b}, 32'd0);
        check("reset in_ready", {31'd0, in_ready_a & in_ready_b}, 32'd1);
        @(posedge clk);
        #1;

        // Multiply latency: accept edge is edge 0, strobe after edge 3 for one cycle
        send(15, 15, st);
        idle();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("latency wr_En k=%0d", k), {31'd0, wr_en_a}, {31'd0, (k == 3)});
        end
        @(posedge clk);
        #1;
        drain("drain latency");

        // Streaming (i, i+1)
        w0 = writes_a;
        for (int i = 0; i < 8; i++) begin
            send(i, i + 1, st);
            check($sformatf("stream stalls i=%0d", i), st, 0);
        end
        idle();
        drain("drain stream");
        check("stream writes", writes_a - w0, 8);

        // Backpressure with 4 results in flight
        w0 = writes_a;
        send(1, 2, st);
        send(3, 4, st);
        send(5, 6, st);
        send(7, 8, st);
        idle();
        wfull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp wr_En", {31'd0, wr_en_a}, 32'd0);
            check("bp in_ready", {31'd0, in_ready_a}, 32'd0);
            check("bp held data", {20'd0, wr_data_a}, 32'd2);
        end
        @(posedge clk);
        #1;
        wfull = 1'b0;
        drain("drain bp");
        check("bp writes", writes_a - w0, 4);

        // Accumulate groups
        acc_mode = 1'b1;
        send(15, 15, st);
        send(1, 2, st);
        send(3, 4, st);
        send(0, 9, st);
        for (int i = 0; i < 4; i++) send(2, 3, st);
        idle();
        drain("drain acc");

        // Saturation on B (A holds 900 unsaturated), then a clean group
        for (int i = 0; i < 4; i++) send(15, 15, st);
        for (int i = 0; i < 4; i++) send(1, 1, st);
        idle();
        drain("drain sat");

        // Mode change 0 -> 1 with two products in flight
        acc_mode = 1'b0;
        send(2, 3, st);
        send(4, 5, st);
        acc_mode = 1'b1;
        send(1, 1, st);
        check("mode change stalls", st, 4);
        for (int i = 0; i < 3; i++) send(1, 1, st);
        idle();
        drain("drain mode");

        // Reset mid-group discards the partial sum
        w0 = writes_a;
        send(3, 3, st);
        send(3, 3, st);
        idle();
        repeat (6) @(posedge clk);
        #1;
        check("partial group busy", {31'd0, busy_a}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_cnt = 0;
        @(negedge clk);
        check("post reset busy A", {31'd0, busy_a}, 32'd0);
        check("post reset busy B", {31'd0, busy_b}, 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("no write after reset", writes_a - w0, 0);

        // Fresh group after reset must start from count 0
        for (int i = 0; i < 4; i++) send(1, 2, st);
        idle();
        drain("drain post reset");

        check("A all results written", writes_a, pushes);
        check("B all results written", writes_b, pushes);
        check("A queue empty", qa.size(), 0);
        check("B queue empty", qb.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/mac_fifo_writer.md
Name: mac_fifo_writer

Overview:
Pipelined multiply / multiply-accumulate producer that drives the write side of the async FIFO in the MAC datapath.
- Accepts operand pairs over a valid/ready handshake.
- Runs them through a parametrised multiplier pipeline.
- Emits either each product or the saturating sum of every ACC_LEN products.
- Never drops or zero-writes a result under backpressure: wFull stalls the whole pipeline losslessly.

Parameters:
WIDTH, 4, operand width (unsigned)
STAGES, 2, multiplier pipeline register stages (>=1)
ACC_LEN, 4, products summed per accumulate group (>=2)
ACC_WIDTH, 2*WIDTH+4, result/accumulator width (>=2*WIDTH)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
acc_mode  in  1  0 = multiply mode, 1 = accumulate mode
in_valid  in  1  operand pair valid
in_ready  out  1  block can accept operands this cycle
D1  in  WIDTH  operand A
D2  in  WIDTH  operand B
wFull  in  1  FIFO full (write domain)
wr_En  out  1  FIFO write strobe
wr_data  out  ACC_WIDTH  FIFO write data
sat_flag  out  1  result on wr_data saturated (valid with wr_En)
busy  out  1  any pipeline stage, partial group, or output register occupied

Behaviour:
- Reset (reset=1 at a clk edge):
  - Clears all stage valids, the accumulator, the group count, the output register and mode_q.
  - After reset: wr_En=0, wr_data=0, sat_flag=0, busy=0, mode_q=0.
  - Reset mid-group or mid-stall discards all in-flight data; nothing is written afterwards.
- Advance: adv = ~out_valid | ~wFull. All pipeline, accumulator and count registers update only when adv=1; otherwise they hold.
- Output strobe: wr_En = out_valid & ~wFull (combinational). wr_data and sat_flag come directly from the output register and are held stable while wFull=1.
- Input acceptance:
  - in_ready = adv & ~mode_block.
  - Accept occurs when in_valid & in_ready; D1*D2 (full 2*WIDTH product) enters stage 1 on that edge.
- Mode handling:
  - mode_q loads acc_mode only while busy=0.
  - mode_block = busy & (acc_mode != mode_q). While mode_block=1, no operands are accepted until the pipeline drains.
  - A mode never mixes within a group.
- Pipeline: the product moves one stage per advancing edge.
- Multiply mode: when the last stage is valid and adv=1, the output register loads the zero-extended product with sat=0. Latency is STAGES+1 edges from accept to out_valid (wr_En high if not full).
- Accumulate mode: when the last stage is valid and adv=1:
  - sum = (count==0 ? 0 : acc) + product, saturated to 2^ACC_WIDTH-1. Group sat bit is sticky within the group.
  - If count==ACC_LEN-1: the output register loads the sum and sat bit, count resets to 0, and the accumulator/sat bit clear.
  - Otherwise: acc = sum and count increments.
  - Partial groups are never emitted. They stay until completed or reset.
- Output register:
  - Clears out_valid on an edge where wr_En=1 and nothing new loads.
  - Loading a new result on the same edge as a write is legal: back-to-back writes at 1 per cycle.
- Bubbles: in_valid low produces pipeline bubbles; they do not advance the count.
- Throughput: 1 operand pair per cycle when wFull=0.
- busy = any stage valid | count!=0 | out_valid.

Test Plan:
- Multiply, defaults: reset, then D1=15, D2=15 accepted at edge 0 -> wr_En=1 after edge 3, wr_data=0x0E1, sat_flag=0, single-cycle strobe.
- Streaming: 8 consecutive pairs (i, i+1), i=0..7, wFull=0 -> 8 consecutive wr_En cycles with data 0,2,6,12,20,30,42,56 in order; in_ready stays 1.
- Backpressure: wFull=1 for 5 cycles while 4 results are in flight -> wr_En=0 and in_ready=0 throughout, wr_data held; after release all 4 results are written in order with no loss or duplicates.
- Accumulate, defaults: acc_mode=1, pairs (15,15),(1,2),(3,4),(0,9) -> exactly one write, wr_data=225+2+12+0=239 (0x0EF), sat_flag=0; a following group of 4x(2,3) -> wr_data=24.
- Saturation: ACC_WIDTH=9, acc_mode=1, 4x(15,15) -> single write, wr_data=511, sat_flag=1; next group 4x(1,1) -> wr_data=4, sat_flag=0.
- Mode change and reset:
  - acc_mode toggled 0->1 with 2 products in flight -> in_ready=0 until busy=0, the 2 products are written as multiply results, then accumulation starts.
  - reset asserted after 2 of 4 accumulate inputs -> no write ever occurs for that group, busy=0 next cycle.
